// File: rtl/qam64_demap_ctrl.sv
// 64-QAM demapper controller: slices I then Q through a shared external slicer and packs
// 6-bit symbols MSB first into bytes. Define QAM64_ERR_CNT_EN to add the err_cnt output.
module qam64_demap_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] frame_len,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_re,
  input  logic [31:0] s_im,
  output logic [31:0] sl_data,
  input  logic [2:0]  sl_bits,
  input  logic        sl_hit,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        err_sym,
  output logic        busy
`ifdef QAM64_ERR_CNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SLICE_I  = 3'd1,
    SLICE_Q  = 3'd2,
    EMIT     = 3'd3,
    EMIT_PAD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] re_q, re_d;
  logic [31:0] im_q, im_d;
  logic [2:0]  hi_q, hi_d;
  logic        err_i_q, err_i_d;
  logic [12:0] buf_q, buf_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;
  logic [15:0] len_q, len_d;
  logic        fe_q, fe_d;
  logic        rdy_q, rdy_d;
  logic [31:0] sl_data_q, sl_data_d;
  logic        m_valid_q, m_valid_d;
  logic [7:0]  m_data_q, m_data_d;
  logic        m_last_q, m_last_d;
  logic        err_sym_q, err_sym_d;
  logic        busy_q, busy_d;

  logic [2:0]  axis_s;
  logic [5:0]  sym_s;
  logic [12:0] app_buf_s;
  logic [3:0]  app_cnt_s;
  logic [15:0] sym_inc_s;
  logic        end_s;
  logic [15:0] eff_len_s;

  // Buffer keeps valid bits left-aligned with zeros below, so the top byte is always the pad byte.
  assign axis_s    = sl_hit ? sl_bits : 3'd0;
  assign sym_s     = {hi_q, axis_s};
  assign app_buf_s = buf_q | ({sym_s, 7'd0} >> cnt_q);
  assign app_cnt_s = cnt_q + 4'd6;
  assign sym_inc_s = sym_cnt_q + 16'd1;
  assign end_s     = (sym_inc_s == len_q);
  assign eff_len_s = (frame_len == 16'd0) ? 16'd1 : frame_len;

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      re_q      <= 32'd0;
      im_q      <= 32'd0;
      hi_q      <= 3'd0;
      err_i_q   <= 1'b0;
      buf_q     <= 13'd0;
      cnt_q     <= 4'd0;
      sym_cnt_q <= 16'd0;
      len_q     <= 16'd0;
      fe_q      <= 1'b0;
      rdy_q     <= 1'b0;
      sl_data_q <= 32'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      m_last_q  <= 1'b0;
      err_sym_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      re_q      <= re_d;
      im_q      <= im_d;
      hi_q      <= hi_d;
      err_i_q   <= err_i_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      sym_cnt_q <= sym_cnt_d;
      len_q     <= len_d;
      fe_q      <= fe_d;
      rdy_q     <= rdy_d;
      sl_data_q <= sl_data_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      err_sym_q <= err_sym_d;
      busy_q    <= busy_d;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    re_d      = re_q;
    im_d      = im_q;
    hi_d      = hi_q;
    err_i_d   = err_i_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    sym_cnt_d = sym_cnt_q;
    len_d     = len_q;
    fe_d      = fe_q;
    err_sym_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && rdy_q) begin
          re_d    = s_re;
          im_d    = s_im;
          state_d = SLICE_I;
          if (sym_cnt_q == 16'd0) begin
            len_d = eff_len_s;
          end else begin
            len_d = len_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SLICE_I: begin
        hi_d    = axis_s;
        err_i_d = ~sl_hit;
        state_d = SLICE_Q;
      end
      SLICE_Q: begin
        err_sym_d = err_i_q | ~sl_hit;
        buf_d     = app_buf_s;
        cnt_d     = app_cnt_s;
        if (end_s) begin
          sym_cnt_d = 16'd0;
          fe_d      = 1'b1;
        end else begin
          sym_cnt_d = sym_inc_s;
          fe_d      = 1'b0;
        end
        if (app_cnt_s >= 4'd8) begin
          state_d = EMIT;
        end else if (end_s) begin
          state_d = EMIT_PAD;
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (m_ready) begin
          buf_d = buf_q << 4'd8;
          cnt_d = cnt_q - 4'd8;
          if (fe_q && (cnt_d != 4'd0)) begin
            state_d = EMIT_PAD;
          end else begin
            state_d = IDLE;
            fe_d    = 1'b0;
          end
        end else begin
          state_d = EMIT;
        end
      end
      EMIT_PAD: begin
        if (m_ready) begin
          buf_d   = 13'd0;
          cnt_d   = 4'd0;
          fe_d    = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = EMIT_PAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming state, registered so they hold while stalled.
  always_comb begin
    sl_data_d = 32'd0;
    m_valid_d = 1'b0;
    m_data_d  = 8'd0;
    m_last_d  = 1'b0;
    case (state_d)
      SLICE_I: sl_data_d = re_d;
      SLICE_Q: sl_data_d = im_d;
      EMIT: begin
        m_valid_d = 1'b1;
        m_data_d  = buf_d[12:5];
        m_last_d  = fe_d && (cnt_d == 4'd8);
      end
      EMIT_PAD: begin
        m_valid_d = 1'b1;
        m_data_d  = buf_d[12:5];
        m_last_d  = 1'b1;
      end
      default: sl_data_d = 32'd0;
    endcase
    rdy_d  = (state_d == IDLE);
    busy_d = (state_d != IDLE) || (sym_cnt_d != 16'd0);
  end

  assign s_ready = rdy_q;
  assign sl_data = sl_data_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign err_sym = err_sym_q;
  assign busy    = busy_q;

`ifdef QAM64_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of illegal-symbol pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else if (err_sym_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end else begin
      err_cnt_q <= err_cnt_q;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_qam64_demap_ctrl.sv
// Scoreboard bench for qam64_demap_ctrl: bit-queue reference model, external slicer model,
// randomized symbols/backpressure plus directed latency, stall and reset cases.
module tb_qam64_demap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_len;
  logic        s_valid, s_ready;
  logic [31:0] s_re, s_im, sl_data;
  logic [2:0]  sl_bits;
  logic        sl_hit;
  logic        m_valid, m_ready;
  logic [7:0]  m_data;
  logic        m_last, err_sym, busy;
`ifdef QAM64_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  qam64_demap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .frame_len(frame_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .sl_data(sl_data), .sl_bits(sl_bits), .sl_hit(sl_hit),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err_sym(err_sym), .busy(busy)
`ifdef QAM64_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  // Levels -7,-5,-3,-1,+1,+3,+5,+7 as IEEE-754 singles, and their slicer Gray codes.
  logic [31:0] lvl_f [8] = '{32'hC0E00000, 32'hC0A00000, 32'hC0400000, 32'hBF800000,
                             32'h3F800000, 32'h40400000, 32'h40A00000, 32'h40E00000};
  logic [2:0]  gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic [31:0] bad_f [4] = '{32'h3F000000, 32'h00000000, 32'h40000000, 32'hC0C00000};

  always_comb begin
    sl_hit  = 1'b0;
    sl_bits = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (sl_data == lvl_f[k]) begin
        sl_hit  = 1'b1;
        sl_bits = gray_tab[k];
      end
    end
  end

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t expq[$];
  bit   bitq[$];
  int   checks = 0, failures = 0;
  int   err_exp = 0, err_cnt_exp = 0, err_seen = 0;
  int   ready_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic void push_exp(input logic [7:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    expq.push_back(e);
  endfunction

  // Reference: append 6 bits, emit a byte whenever 8 are present, pad the residue at frame end.
  function automatic void model_sym(input logic [5:0] bits, input bit last);
    logic [7:0] b;
    for (int i = 5; i >= 0; i--) bitq.push_back(bits[i]);
    if (bitq.size() >= 8) begin
      for (int i = 7; i >= 0; i--) b[i] = bitq.pop_front();
      push_exp(b, last && (bitq.size() == 0));
    end
    if (last && bitq.size() > 0) begin
      b = 8'd0;
      for (int i = 7; i >= 0; i--) if (bitq.size() > 0) b[i] = bitq.pop_front();
      push_exp(b, 1'b1);
    end
  endfunction

  task automatic gen_axis(input bit allow_bad, output logic [31:0] f, output logic [2:0] g,
                          output bit bad);
    logic [2:0] idx;
    if (allow_bad && $urandom_range(0, 7) == 0) begin
      f   = bad_f[$urandom_range(0, 3)];
      g   = 3'd0;
      bad = 1'b1;
    end else begin
      idx = 3'($urandom_range(0, 7));
      f   = lvl_f[idx];
      g   = idx ^ (idx >> 1);
      bad = 1'b0;
    end
  endtask

  task automatic drive_sym(input logic [31:0] re, input logic [31:0] im);
    int n;
    @(posedge clk);
    #1;
    s_re = re;
    s_im = im;
    s_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      timeout_fail("accept_timeout");
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
    end
  endtask

  task automatic rand_sym(input bit last, input bit allow_bad);
    logic [31:0] fr, fi;
    logic [2:0]  gr, gi;
    bit          br, bi;
    gen_axis(allow_bad, fr, gr, br);
    gen_axis(allow_bad, fi, gi, bi);
    model_sym({gr, gi}, last);
    if (br || bi) begin
      err_exp++;
      err_cnt_exp++;
    end
    drive_sym(fr, fi);
  endtask

  task automatic wait_drain(input int lim);
    int n;
    n = 0;
    while (expq.size() != 0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (expq.size() != 0) timeout_fail("drain_timeout");
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"}, {24'd0, m_data}, 32'd0);
    chk({tag, "_m_last"}, {31'd0, m_last}, 32'd0);
    chk({tag, "_err_sym"}, {31'd0, err_sym}, 32'd0);
    chk({tag, "_sl_data"}, sl_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Downstream backpressure driver.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = ($urandom_range(0, 3) != 0);
        1:       m_ready = 1'b0;
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compare each accepted byte against the scoreboard head, count err pulses.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got 0x%0h last=%0d expected none", m_data, m_last);
        end else begin
          e = expq.pop_front();
          chk("byte_data", {24'd0, m_data}, {24'd0, e.d});
          chk("byte_last", {31'd0, m_last}, {31'd0, e.l});
        end
      end
      if (rst_n && err_sym) err_seen++;
    end
  end

  initial begin
    int len, eff, n;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_re = 32'd0;
    s_im = 32'd0;
    frame_len = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Illegal I axis: symbol 000110 padded to 0x18, one err pulse.
    frame_len = 16'd1;
    push_exp(8'h18, 1'b1);
    err_exp++;
    err_cnt_exp++;
    drive_sym(32'h3F000000, 32'h3F800000);
    repeat (6) @(negedge clk);
    chk("err_sym_illegal", err_seen, err_exp);
`ifdef QAM64_ERR_CNT_EN
    chk("err_cnt_one", {16'd0, err_cnt}, 32'd1);
`endif

    // Four (-7,+7) symbols.
    frame_len = 16'd4;
    push_exp(8'h10, 1'b0);
    push_exp(8'h41, 1'b0);
    push_exp(8'h04, 1'b1);
    repeat (4) drive_sym(32'hC0E00000, 32'h40E00000);

    // Single (+1,-3) symbol with slice latency.
    frame_len = 16'd1;
    push_exp(8'hCC, 1'b1);
    drive_sym(32'h3F800000, 32'hC0400000);
    @(negedge clk);
    chk("lat_t1_sl_data", sl_data, 32'h3F800000);
    chk("lat_t1_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk("lat_t2_sl_data", sl_data, 32'hC0400000);
    chk("lat_t2_s_ready", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    chk("lat_t3_sl_data", sl_data, 32'd0);
    chk("lat_t3_m_valid", {31'd0, m_valid}, 32'd1);
    chk("lat_t3_s_ready", {31'd0, s_ready}, 32'd0);

    // Output stall: held five cycles, released by m_ready=1.
    wait_drain(200);
    ready_mode = 1;
    repeat (2) @(posedge clk);
    push_exp(8'hCC, 1'b1);
    drive_sym(32'h3F800000, 32'hC0400000);
    n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) timeout_fail("stall_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      chk("stall_m_data", {24'd0, m_data}, 32'h000000CC);
      chk("stall_m_last", {31'd0, m_last}, 32'd1);
      chk("stall_m_valid", {31'd0, m_valid}, 32'd1);
      chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
      @(negedge clk);
    end
    ready_mode = 2;
    repeat (2) @(negedge clk);
    chk("stall_release_m_valid", {31'd0, m_valid}, 32'd0);
    ready_mode = 0;

    // Random frames; frame_len scrambled after the first symbol must not matter.
    for (int f = 0; f < 25; f++) begin
      len = (f == 3) ? 0 : int'($urandom_range(1, 7));
      eff = (len == 0) ? 1 : len;
      frame_len = 16'(len);
      for (int s = 0; s < eff; s++) begin
        rand_sym(s == eff - 1, 1'b1);
        if (s == 0) frame_len = 16'($urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
      end
    end
    wait_drain(3000);

    // Reset after 2 of 4 symbols; next frame must start clean.
    frame_len = 16'd4;
    rand_sym(1'b0, 1'b0);
    rand_sym(1'b0, 1'b0);
    wait_drain(200);
    repeat (2) @(negedge clk);
    chk("busy_partial", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bitq.delete();
    err_cnt_exp = 0;
    repeat (2) @(negedge clk);
    chk_reset_outputs("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    frame_len = 16'd4;
    for (int s = 0; s < 4; s++) rand_sym(s == 3, 1'b1);
    wait_drain(500);
    repeat (5) @(negedge clk);

    chk("scoreboard_empty", expq.size(), 32'd0);
    chk("err_sym_total", err_seen, err_exp);
`ifdef QAM64_ERR_CNT_EN
    chk("err_cnt_final", {16'd0, err_cnt}, err_cnt_exp);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end
endmodule
